// File: rtl/mcu_pkg.sv
// mcu_pkg: shared definitions for the MCU sequencer.
//   state_t         - top-level state encoding that is driven onto o_state.
//   MIN_LEN         - shortest row length accepted on i_Start.
//   sub_width()     - bit width of the PROC substate bus for a given N.
//   sel_width()     - bit width of the memory-select bus for a given N.
package mcu_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_PROC = 2'b01,
        ST_OUT  = 2'b10,
        ST_IDLE = 2'b11
    } state_t;

    localparam int MIN_LEN = 3;

    // A one-valued substate range would give $clog2 == 0; keep at least one bit.
    function automatic int sub_width(input int n);
        return (n / 2 + 1 > 1) ? $clog2(n / 2 + 1) : 1;
    endfunction

    function automatic int sel_width(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/mcu_addr_counter.sv
// mcu_addr_counter: enabled wrapping address counter.
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - synchronous return to 0 (wins over en)
//   en         - advance by one; wraps to 0 after reaching limit
//   limit      - last value before the wrap
//   count      - current value
//   tc         - terminal count: count == limit
module mcu_addr_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_reg;

    assign count = count_reg;
    assign tc    = (count_reg == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= tc ? '0 : count_reg + W'(1);
        end
    end

endmodule

// File: rtl/mcu_sequencer.sv
// mcu_sequencer: control side of the MCU mux array for one image strip.
// Loads N+2 row memories, runs two in-place convolution half-passes, then
// streams the memories out under a valid/ready handshake.
//   i_CLK, i_nRST   - clock, asynchronous active-low reset
//   i_Start         - start pulse (IDLE only), i_ImgLength = row length L
//   i_Valid         - input pixel strobe (LOAD only)
//   i_OutReady      - downstream accepts o_Data
//   o_state         - 00 LOAD, 01 PROC, 10 OUT, 11 IDLE
//   o_substate      - PROC half-pass select
//   o_memSelect     - memory for LOAD writes / OUT presentation
//   o_RdAddr        - common read address (memories have a 1-cycle read)
//   o_WrAddr/o_WrEn - common write address, per-memory write enables
//   o_ConvValid     - convolver input column valid
//   o_OutValid      - o_Data valid
//   o_Busy, o_Done  - not-IDLE flag, end-of-strip pulse
module mcu_sequencer
    import mcu_pkg::*;
#(
    parameter int N           = 2,
    parameter int BITS_IMAGEN = 11,
    parameter int BITS_ADDR   = 10,
    parameter int STATES      = 3,
    parameter int CONV_LAT    = 2
) (
    input  logic                        i_CLK,
    input  logic                        i_nRST,
    input  logic                        i_Start,
    input  logic [BITS_ADDR-1:0]        i_ImgLength,
    input  logic                        i_Valid,
    input  logic                        i_OutReady,
    output logic [$clog2(STATES)-1:0]   o_state,
    output logic [sub_width(N)-1:0]     o_substate,
    output logic [sel_width(N)-1:0]     o_memSelect,
    output logic [BITS_ADDR-1:0]        o_RdAddr,
    output logic [BITS_ADDR-1:0]        o_WrAddr,
    output logic [N+1:0]                o_WrEn,
    output logic                        o_ConvValid,
    output logic                        o_OutValid,
    output logic                        o_Busy,
    output logic                        o_Done
);

    localparam int NMEM  = N + 2;
    localparam int SUB_W = sub_width(N);
    localparam int SEL_W = sel_width(N);
    localparam int ST_W  = $clog2(STATES);

    generate
        if (N < 2 || (N % 2) != 0 || CONV_LAT < 2 || BITS_IMAGEN < 1) begin : g_bad_params
            $error("mcu_sequencer: N must be even and >= 2, CONV_LAT >= 2");
        end
    endgenerate

    state_t               state_reg;
    logic [SUB_W-1:0]     sub_reg;
    logic [SEL_W-1:0]     sel_reg;
    logic [BITS_ADDR-1:0] len_reg;
    logic                 rd_active_reg;
    logic                 out_valid_reg;
    logic                 done_reg;

    logic [BITS_ADDR-1:0] limit;
    logic                 start_ok, load_wr, transfer, last_sel;
    logic                 addr_en, sweep_en;
    logic [BITS_ADDR-1:0] addr_cnt, sweep_cnt;
    logic                 addr_tc, sweep_tc;

    assign limit    = len_reg - BITS_ADDR'(1);
    assign start_ok = (state_reg == ST_IDLE) && i_Start && (i_ImgLength >= BITS_ADDR'(MIN_LEN));
    assign load_wr  = (state_reg == ST_LOAD) && i_Valid;
    assign transfer = (state_reg == ST_OUT) && out_valid_reg && i_OutReady;
    assign last_sel = (sel_reg == SEL_W'(NMEM - 1));
    assign addr_en  = load_wr || transfer;
    assign sweep_en = (state_reg == ST_PROC) && rd_active_reg;

    // addr: LOAD write position, then OUT position of the pixel on o_Data.
    mcu_addr_counter #(.W(BITS_ADDR)) u_addr (
        .clk   (i_CLK),
        .rst_n (i_nRST),
        .clear (start_ok),
        .en    (addr_en),
        .limit (limit),
        .count (addr_cnt),
        .tc    (addr_tc)
    );

    // PROC read sweep, restarted for each half-pass by its own wrap.
    mcu_addr_counter #(.W(BITS_ADDR)) u_sweep (
        .clk   (i_CLK),
        .rst_n (i_nRST),
        .clear (start_ok),
        .en    (sweep_en),
        .limit (limit),
        .count (sweep_cnt),
        .tc    (sweep_tc)
    );

    // Write-back delay line: stage 0 is the read strobe seen at the memory
    // output (convolver input valid), stage CONV_LAT lines up with the
    // convolver result.
    logic [CONV_LAT:0]    wb_vld_reg;
    logic [BITS_ADDR-1:0] wb_addr_reg [CONV_LAT+1];
    logic                 wb_valid, wb_last;
    logic [BITS_ADDR-1:0] wb_addr;
    logic [NMEM-1:0]      wb_mask;

    always_ff @(posedge i_CLK or negedge i_nRST) begin
        if (!i_nRST) begin
            wb_vld_reg <= '0;
            for (int i = 0; i <= CONV_LAT; i++) wb_addr_reg[i] <= '0;
        end else begin
            wb_vld_reg     <= {wb_vld_reg[CONV_LAT-1:0], sweep_en};
            wb_addr_reg[0] <= sweep_cnt;
            for (int i = 1; i <= CONV_LAT; i++) wb_addr_reg[i] <= wb_addr_reg[i-1];
        end
    end

    assign wb_valid = wb_vld_reg[CONV_LAT];
    assign wb_addr  = wb_addr_reg[CONV_LAT];
    assign wb_last  = wb_valid && (wb_addr == limit);

    // Half-pass s writes back into memories 2s .. 2s+N-1.
    for (genvar gi = 0; gi < NMEM; gi++) begin : g_wb_mask
        assign wb_mask[gi] = (gi >= 2 * int'(sub_reg)) && (gi < 2 * int'(sub_reg) + N);
    end

    always_ff @(posedge i_CLK or negedge i_nRST) begin
        if (!i_nRST) begin
            state_reg     <= ST_IDLE;
            sub_reg       <= '0;
            sel_reg       <= '0;
            len_reg       <= '0;
            rd_active_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        len_reg   <= i_ImgLength;
                        sel_reg   <= '0;
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (load_wr && addr_tc) begin
                        if (last_sel) begin
                            sel_reg       <= '0;
                            sub_reg       <= '0;
                            rd_active_reg <= 1'b1;
                            state_reg     <= ST_PROC;
                        end else begin
                            sel_reg <= sel_reg + SEL_W'(1);
                        end
                    end
                end
                ST_PROC: begin
                    if (sweep_en && sweep_tc) rd_active_reg <= 1'b0;
                    // The last write-back trails the last read by CONV_LAT+1
                    // cycles, so it never coincides with the sweep end above.
                    if (wb_last) begin
                        if (sub_reg == '0) begin
                            sub_reg       <= SUB_W'(1);
                            rd_active_reg <= 1'b1;
                        end else begin
                            sub_reg       <= '0;
                            sel_reg       <= '0;
                            out_valid_reg <= 1'b0;
                            state_reg     <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                    end else if (transfer && addr_tc) begin
                        if (last_sel) begin
                            out_valid_reg <= 1'b0;
                            done_reg      <= 1'b1;
                            sel_reg       <= '0;
                            state_reg     <= ST_IDLE;
                        end else begin
                            sel_reg <= sel_reg + SEL_W'(1);
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // In OUT, addr tracks the pixel being presented. The read address looks
    // ahead to the next pixel only on a transfer; under stall it re-reads the
    // presented pixel so the memory output stays put.
    always_comb begin
        o_RdAddr = '0;
        o_WrAddr = '0;
        o_WrEn   = '0;
        case (state_reg)
            ST_LOAD: begin
                o_WrAddr = addr_cnt;
                if (i_Valid) o_WrEn = NMEM'(1) << sel_reg;
            end
            ST_PROC: begin
                o_RdAddr = sweep_cnt;
                if (wb_valid) begin
                    o_WrEn   = wb_mask;
                    o_WrAddr = wb_addr;
                end
            end
            ST_OUT: begin
                if (transfer) o_RdAddr = addr_tc ? '0 : addr_cnt + BITS_ADDR'(1);
                else          o_RdAddr = addr_cnt;
            end
            default: ;
        endcase
    end

    assign o_state     = ST_W'(state_reg);
    assign o_substate  = sub_reg;
    assign o_memSelect = sel_reg;
    assign o_ConvValid = wb_vld_reg[0];
    assign o_OutValid  = out_valid_reg;
    assign o_Busy      = (state_reg != ST_IDLE);
    assign o_Done      = done_reg;

endmodule

// File: tb/tb_mcu_sequencer.sv
// tb_mcu_sequencer: directed runs with randomized pixels, gaps, ready
// patterns and ignored pulses. The bench models the memories and a simple
// convolver (result = column data of memory 2s XOR K, CONV_LAT late) and
// predicts the output stream from the strip-level rules.
module tb_mcu_sequencer;

    localparam int N    = 2;
    localparam int BI   = 11;
    localparam int BA   = 10;
    localparam int ST   = 3;
    localparam int CL   = 2;
    localparam int NMEM = N + 2;
    localparam logic [BI-1:0] K = 11'h2A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, valid, out_ready;
    logic [BA-1:0] img_len;
    logic [BI-1:0] din;

    logic [1:0]      o_state;
    logic [0:0]      o_substate;
    logic [1:0]      o_memSelect;
    logic [BA-1:0]   o_RdAddr, o_WrAddr;
    logic [NMEM-1:0] o_WrEn;
    logic            o_ConvValid, o_OutValid, o_Busy, o_Done;

    int n_checks = 0;
    int n_fail   = 0;

    mcu_sequencer #(
        .N(N), .BITS_IMAGEN(BI), .BITS_ADDR(BA), .STATES(ST), .CONV_LAT(CL)
    ) dut (
        .i_CLK       (clk),
        .i_nRST      (rst_n),
        .i_Start     (start),
        .i_ImgLength (img_len),
        .i_Valid     (valid),
        .i_OutReady  (out_ready),
        .o_state     (o_state),
        .o_substate  (o_substate),
        .o_memSelect (o_memSelect),
        .o_RdAddr    (o_RdAddr),
        .o_WrAddr    (o_WrAddr),
        .o_WrEn      (o_WrEn),
        .o_ConvValid (o_ConvValid),
        .o_OutValid  (o_OutValid),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done)
    );

    // Environment: row memories with registered read, and the convolver.
    logic [BI-1:0] mem   [NMEM][1024];
    logic [BI-1:0] rdata [NMEM];
    logic [BI-1:0] cpipe [CL];

    always @(posedge clk) begin
        for (int m = 0; m < NMEM; m++) begin
            rdata[m] <= mem[m][o_RdAddr];
            if (o_WrEn[m]) mem[m][o_WrAddr] <= (o_state == 2'b00) ? din : cpipe[CL-1];
        end
        cpipe[0] <= rdata[2 * o_substate] ^ K;
        for (int i = 1; i < CL; i++) cpipe[i] <= cpipe[i-1];
    end

    // Expected memory contents, updated at strip level.
    logic [BI-1:0] exp_mem [NMEM][8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string pfx);
        chk({pfx, "_state"},  o_state, 3);
        chk({pfx, "_sub"},    o_substate, 0);
        chk({pfx, "_sel"},    o_memSelect, 0);
        chk({pfx, "_rdaddr"}, o_RdAddr, 0);
        chk({pfx, "_wraddr"}, o_WrAddr, 0);
        chk({pfx, "_wren"},   o_WrEn, 0);
        chk({pfx, "_convv"},  o_ConvValid, 0);
        chk({pfx, "_outv"},   o_OutValid, 0);
        chk({pfx, "_busy"},   o_Busy, 0);
        chk({pfx, "_done"},   o_Done, 0);
    endtask

    task automatic do_start(input int len);
        @(posedge clk); #1;
        start = 1'b1; img_len = BA'(len); valid = 1'b0;
        @(negedge clk);
        chk("start_idle", o_state, 3);
    endtask

    // k-th accepted pixel lands in memory k/L at address k%L, regardless of gaps.
    task automatic do_load(input int len, input bit gaps);
        int k = 0;
        int budget = 0;
        while (k < NMEM * len && budget < 300) begin
            @(posedge clk); #1;
            start   = (k > 0) && ($urandom_range(0, 5) == 0);
            img_len = BA'($urandom_range(3, 8));
            valid   = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            din     = BI'($urandom);
            @(negedge clk);
            budget++;
            chk("ld_state", o_state, 0);
            chk("ld_busy", o_Busy, 1);
            if (valid) begin
                chk("ld_wren", o_WrEn, 32'(1) << (k / len));
                chk("ld_wraddr", o_WrAddr, k % len);
                chk("ld_sel", o_memSelect, k / len);
                exp_mem[k / len][k % len] = din;
                k++;
            end else begin
                chk("ld_gap_wren", o_WrEn, 0);
            end
        end
        if (k < NMEM * len) chk("ld_timeout", k, NMEM * len);
    endtask

    task automatic do_proc(input int len);
        int t = len + 1 + CL;
        int s, j;
        bit wb;
        logic [BI-1:0] v;
        for (int c = 0; c < 2 * t; c++) begin
            @(posedge clk); #1;
            start   = ($urandom_range(0, 3) == 0);
            valid   = 1'($urandom_range(0, 1));
            img_len = 4;
            @(negedge clk);
            s  = c / t;
            j  = c % t;
            wb = (j >= 1 + CL) && (j <= len + CL);
            chk("pr_state", o_state, 1);
            chk("pr_sub", o_substate, s);
            chk("pr_sel", o_memSelect, 0);
            chk("pr_convvalid", o_ConvValid, 32'((j >= 1) && (j <= len)));
            if (j < len) chk("pr_rdaddr", o_RdAddr, j);
            chk("pr_wren", o_WrEn, wb ? (((32'(1) << N) - 1) << (2 * s)) : 0);
            if (wb) chk("pr_wraddr", o_WrAddr, j - 1 - CL);
        end
        start = 1'b0;
        valid = 1'b0;
        for (int hs = 0; hs < 2; hs++) begin
            for (int a = 0; a < len; a++) begin
                v = exp_mem[2 * hs][a] ^ K;
                for (int d = 2 * hs; d < 2 * hs + N; d++) exp_mem[d][a] = v;
            end
        end
    endtask

    // mode 0: ready toggles 1,0,1,0; 1: random; 2: always high.
    task automatic do_out(input int len, input int mode, input int stop_after, output int cycles);
        int idx = 0;
        int c = 0;
        bit stalled = 1'b0;
        logic [BI-1:0] prev = '0;
        logic [BI-1:0] data;
        while (idx < NMEM * len && idx < stop_after && c < 40 * NMEM * len) begin
            @(posedge clk); #1;
            start = 1'b0;
            valid = 1'($urandom_range(0, 1));
            case (mode)
                0:       out_ready = (c % 2 == 0);
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            @(negedge clk);
            data = rdata[o_memSelect];
            chk("out_state", o_state, 2);
            chk("out_wren", o_WrEn, 0);
            chk("out_no_done", o_Done, 0);
            if (c == 0) chk("out_first_invalid", o_OutValid, 0);
            if (c == 1) chk("out_valid_rise", o_OutValid, 1);
            if (stalled) chk("out_stall_stable", data, prev);
            if (o_OutValid && out_ready) begin
                chk("out_data", data, exp_mem[idx / len][idx % len]);
                chk("out_sel", o_memSelect, idx / len);
                idx++;
            end
            stalled = o_OutValid && !out_ready;
            prev    = data;
            c++;
        end
        if (idx < stop_after && idx < NMEM * len) chk("out_timeout", idx, NMEM * len);
        cycles = c;
    endtask

    task automatic do_done();
        @(posedge clk); #1;
        out_ready = 1'b0;
        valid     = 1'b0;
        @(negedge clk);
        chk("done_pulse", o_Done, 1);
        chk("done_state", o_state, 3);
        chk("done_busy", o_Busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_once", o_Done, 0);
    endtask

    initial begin
        int len;
        int cyc;
        rst_n = 1'b0; start = 1'b0; valid = 1'b0; out_ready = 1'b0;
        img_len = '0; din = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // i_Valid in IDLE writes nothing; a start with L=2 is ignored.
        @(posedge clk); #1;
        valid = 1'b1;
        @(negedge clk);
        chk("idle_valid_wren", o_WrEn, 0);
        @(posedge clk); #1;
        valid = 1'b0; start = 1'b1; img_len = 2;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("short_start_state", o_state, 3);
        chk("short_start_busy", o_Busy, 0);

        // Run A: L=4, gap-free load, toggling ready.
        do_start(4);
        do_load(4, 1'b0);
        do_proc(4);
        do_out(4, 0, 1000, cyc);
        do_done();

        // Run B: random length, gappy load, random ready.
        len = $urandom_range(3, 8);
        do_start(len);
        do_load(len, 1'b1);
        do_proc(len);
        do_out(len, 1, 1000, cyc);
        do_done();

        // Run C: reset in the middle of OUT.
        do_start(4);
        do_load(4, 1'b1);
        do_proc(4);
        do_out(4, 1, 6, cyc);
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("midrst_no_done", o_Done, 0);
            chk("midrst_idle", o_state, 3);
        end

        // Run D: normal run after reset, full-rate output.
        do_start(4);
        do_load(4, 1'b0);
        do_proc(4);
        do_out(4, 2, 1000, cyc);
        chk("out_throughput", cyc, 1 + NMEM * 4);
        do_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
